// File: rtl/mdu_pkg.sv
// Shared MDU op codes, default latencies and op classification helpers.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by MDU_MADD_EN.
package mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_NONE  = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd8;
  localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 4'd9;
  localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 4'd10;

  localparam int MDU_MULT_LAT = 5;
  localparam int MDU_DIV_LAT  = 10;

  // Ops that occupy the unit for the multiply latency.
  function automatic logic mdu_is_mult(input logic [MDU_OP_W-1:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
         (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic mdu_is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_core_calc.sv
// Combinational 64-bit {hi,lo} result for a captured MDU op; upd_o=0 means keep HI/LO.
// Accumulate ops (MDU_MADD_EN) read the current {hi,lo} as their base.
module mdu_core_calc
  import mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [31:0]         a_i,
  input  logic [31:0]         b_i,
  input  logic [63:0]         hilo_i,
  output logic [63:0]         res_o,
  output logic                upd_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic        div_ovf;

  assign prod_s  = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u  = {32'd0, a_i} * {32'd0, b_i};
  assign quo_s   = $signed(a_i) / $signed(b_i);
  assign rem_s   = $signed(a_i) % $signed(b_i);
  // The one signed quotient that does not fit in 32 bits; pin its MIPS result.
  assign div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  always_comb begin
    res_o = hilo_i;
    upd_o = 1'b1;
    case (op_i)
      MDU_MULT:  res_o = prod_s;
      MDU_MULTU: res_o = prod_u;
      MDU_DIV: begin
        if (b_i == 32'd0)  upd_o = 1'b0;
        else if (div_ovf)  res_o = {32'd0, 32'h8000_0000};
        else               res_o = {rem_s, quo_s};
      end
      MDU_DIVU: begin
        if (b_i == 32'd0) upd_o = 1'b0;
        else              res_o = {a_i % b_i, a_i / b_i};
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  res_o = hilo_i + prod_s;
      MDU_MADDU: res_o = hilo_i + prod_u;
      MDU_MSUB:  res_o = hilo_i - prod_s;
      MDU_MSUBU: res_o = hilo_i - prod_u;
`endif
      default:   upd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with private HI/LO and a fixed-latency busy countdown.
// Starts while busy are dropped; MDU_MADD_EN adds the MADD/MSUB accumulate family.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_LAT,
  parameter int DIV_CYCLES  = MDU_DIV_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         A,
  input  logic [31:0]         B,
  output logic                busy,
  output logic [31:0]         hi,
  output logic [31:0]         lo
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MDU_OP_W-1:0] op_q,  op_d;
  logic [31:0]         a_q,   a_d;
  logic [31:0]         b_q,   b_d;
  logic [31:0]         hi_q,  hi_d;
  logic [31:0]         lo_q,  lo_d;
  logic [63:0]         calc_res;
  logic                calc_upd;

  mdu_core_calc u_calc (
    .op_i   (op_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .hilo_i ({hi_q, lo_q}),
    .res_o  (calc_res),
    .upd_o  (calc_upd)
  );

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      // Results land on the edge the countdown reaches zero.
      if (cnt_q == CNT_W'(1) && calc_upd) {hi_d, lo_d} = calc_res;
    end else if (start) begin
      if (op == MDU_MTHI) begin
        hi_d = A;
      end else if (op == MDU_MTLO) begin
        lo_d = A;
      end else if (mdu_is_mult(op) || mdu_is_div(op)) begin
        op_d  = op;
        a_d   = A;
        b_d   = B;
        cnt_d = mdu_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= MDU_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
